// File: rtl/zeptobars_cfg_loader.sv
// Host-side writer for the configuration shift chain: serializes a word MSB-first and captures the displaced contents.
// Define ZEPTOBARS_CFG_VERIFY_EN to add an automatic second pass whose capture is compared against the word.
module zeptobars_cfg_loader #(
    parameter int WIDTH = 12,
    parameter int DIV   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             shift_clk,
    output logic             shift_dta,
    input  logic             chain_tail,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] readback,
    output logic             mismatch
);
    // state | meaning
    // IDLE  | waiting for a word, cfg_ready high
    // LOW   | shift_clk low, data presented, tail sampled on the last cycle
    // HIGH  | shift_clk high, chain shifts on entry
    // FIN   | one-cycle done pulse

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   readback_q, readback_d;
    logic               shift_clk_q, shift_clk_d;
    logic               shift_dta_q, shift_dta_d;
    logic               done_q, done_d;
    logic               tail_s1_q, tail_s2_q;
`ifdef ZEPTOBARS_CFG_VERIFY_EN
    logic               pass_q, pass_d;
    logic               mismatch_q, mismatch_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            readback_q  <= '0;
            shift_clk_q <= 1'b0;
            shift_dta_q <= 1'b0;
            done_q      <= 1'b0;
            tail_s1_q   <= 1'b0;
            tail_s2_q   <= 1'b0;
`ifdef ZEPTOBARS_CFG_VERIFY_EN
            pass_q      <= 1'b0;
            mismatch_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            readback_q  <= readback_d;
            shift_clk_q <= shift_clk_d;
            shift_dta_q <= shift_dta_d;
            done_q      <= done_d;
            tail_s1_q   <= chain_tail;
            tail_s2_q   <= tail_s1_q;
`ifdef ZEPTOBARS_CFG_VERIFY_EN
            pass_q      <= pass_d;
            mismatch_q  <= mismatch_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        readback_d = readback_q;
`ifdef ZEPTOBARS_CFG_VERIFY_EN
        pass_d     = pass_q;
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    word_d  = cfg_data;
                    bit_d   = BIT_TOP;
                    cnt_d   = PH_LAST;
                    state_d = S_LOW;
`ifdef ZEPTOBARS_CFG_VERIFY_EN
                    pass_d     = 1'b0;
                    mismatch_d = 1'b0;
`endif
                end
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    readback_d[bit_q] = tail_s2_q;
                    cnt_d   = PH_LAST;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    cnt_d = PH_LAST;
                    if (bit_q == '0) begin
`ifdef ZEPTOBARS_CFG_VERIFY_EN
                        if (!pass_q) begin
                            // Re-shifting the same word displaces what the load just wrote.
                            pass_d  = 1'b1;
                            bit_d   = BIT_TOP;
                            state_d = S_LOW;
                        end else begin
                            mismatch_d = (readback_q != word_q);
                            state_d    = S_FIN;
                        end
`else
                        state_d = S_FIN;
`endif
                    end else begin
                        bit_d   = bit_q - BIT_W'(1);
                        state_d = S_LOW;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Data only moves on entry to LOW, so it never changes across a rising shift_clk.
        shift_clk_d = (state_d == S_HIGH);
        shift_dta_d = (state_d == S_LOW) ? word_d[bit_d] : shift_dta_q;
        done_d      = (state_d == S_FIN);
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign shift_clk = shift_clk_q;
    assign shift_dta = shift_dta_q;
    assign done      = done_q;
    assign readback  = readback_q;
`ifdef ZEPTOBARS_CFG_VERIFY_EN
    assign mismatch  = mismatch_q;
`else
    assign mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_zeptobars_cfg_loader.sv
// Self-checking bench for zeptobars_cfg_loader with a behavioural shift-chain model.
// Expectations follow ZEPTOBARS_CFG_VERIFY_EN when it is defined for the build.
module tb_zeptobars_cfg_loader;
    localparam int WIDTH = 12;
    localparam int DIV   = 4;
    localparam int CNT_W = 8;
`ifdef ZEPTOBARS_CFG_VERIFY_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam int DONE_CYC = 2 * DIV * WIDTH * NPASS + 1;
    localparam int LIMIT    = DONE_CYC + 50;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] cfg_data = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic             shift_clk;
    logic             shift_dta;
    logic             chain_tail;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] readback;
    logic             mismatch;

    zeptobars_cfg_loader #(.WIDTH(WIDTH), .DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .shift_clk(shift_clk), .shift_dta(shift_dta),
        .chain_tail(chain_tail), .busy(busy), .done(done), .readback(readback),
        .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Shift chain: bits move toward the tail on each shift_clk rise.
    logic [WIDTH-1:0] chain = '0;
    logic [WIDTH-1:0] preload_val = '0;
    logic             preload_req = 1'b0;
    bit               stuck = 1'b0;
    assign chain_tail = stuck ? 1'b0 : chain[WIDTH-1];
    always @(posedge shift_clk or posedge preload_req) begin
        if (preload_req) chain = preload_val;
        else             chain = {chain[WIDTH-2:0], shift_dta};
    end

    // Protocol monitor sampled on the falling clk edge.
    int   rises = 0, prot_err = 0, accepts = 0;
    int   stable = 0, hlen = 0;
    logic pclk = 1'b0, pdta = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pclk = 1'b0; pdta = 1'b0; stable = 0; hlen = 0;
        end else begin
            if (shift_dta == pdta) stable++; else stable = 1;
            if (shift_clk && !pclk) begin
                rises++;
                if (stable < DIV + 1) prot_err++;
                hlen = 1;
            end else if (shift_clk) begin
                hlen++;
                if (shift_dta != pdta) prot_err++;
            end else if (pclk && hlen != DIV) begin
                prot_err++;
            end
            if (cfg_valid && cfg_ready) accepts++;
            pclk = shift_clk;
            pdta = shift_dta;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_rb(input logic [WIDTH-1:0] old_chain,
                                                input logic [WIDTH-1:0] w, input bit stk);
        if (stk)        return '0;
        if (NPASS == 2) return w;
        return old_chain;
    endfunction

    function automatic logic exp_mm(input logic [WIDTH-1:0] rb, input logic [WIDTH-1:0] w);
        return (NPASS == 2) && (rb != w);
    endfunction

    task automatic preload(input logic [WIDTH-1:0] v);
        preload_val = v;
        preload_req = 1'b1;
        #1;
        preload_req = 1'b0;
    endtask

    task automatic start_load(input logic [WIDTH-1:0] w);
        cfg_data  = w;
        cfg_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input bit wiggle, output int lat, output int busy_bad);
        lat = 1;
        busy_bad = 0;
        while (done !== 1'b1 && lat < LIMIT) begin
            if (busy !== 1'b1) busy_bad++;
            if (wiggle) cfg_data = WIDTH'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b1) busy_bad++;
    endtask

    task automatic do_load(input string tag, input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] old_chain, rb;
        int r0, p0, lat, bb;
        old_chain = chain;
        r0 = rises;
        p0 = prot_err;
        start_load(w);
        cfg_valid = 1'b0;
        wait_done(1'b0, lat, bb);
        rb = exp_rb(old_chain, w, stuck);
        chk({tag, "_done_cycle"}, lat, DONE_CYC);
        chk({tag, "_busy"}, bb, 0);
        chk({tag, "_chain"}, chain, w);
        chk({tag, "_readback"}, readback, rb);
        chk({tag, "_mismatch"}, mismatch, exp_mm(rb, w));
        chk({tag, "_rises"}, rises - r0, WIDTH * NPASS);
        chk({tag, "_protocol"}, prot_err - p0, 0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, {busy, cfg_ready}, 2'b01);
    endtask

    initial begin
        logic [WIDTH-1:0] w, w2, rb;
        int lat, bb, a0;

        // Reset values
        #1;
        chk("rst_outputs", {shift_clk, shift_dta, busy, done, mismatch}, 0);
        chk("rst_readback", readback, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", cfg_ready, 1);
        chk("rst_idle_outputs", {shift_clk, shift_dta, busy, done, mismatch}, 0);

        do_load("t1_a5c", 12'hA5C);

        preload(12'h3F0);
        do_load("t2_00f", 12'h00F);
        do_load("t2_fff", 12'hFFF);

        for (int i = 0; i < 4; i++) begin
            preload(WIDTH'($urandom));
            do_load($sformatf("rand%0d", i), WIDTH'($urandom));
        end

        // Valid held high and data wiggling while busy
        preload(WIDTH'($urandom));
        w  = WIDTH'($urandom);
        w2 = WIDTH'($urandom);
        a0 = accepts;
        start_load(w);
        wait_done(1'b1, lat, bb);
        chk("t4_done_cycle", lat, DONE_CYC);
        chk("t4_chain_first", chain, w);
        chk("t4_single_accept", accepts - a0, 1);
        cfg_data = w2;
        @(posedge clk); #1;
        chk("t4_ready_after_done", cfg_ready, 1);
        w = chain;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        wait_done(1'b0, lat, bb);
        chk("t4_second_done", lat, DONE_CYC);
        chk("t4_second_chain", chain, w2);
        chk("t4_second_readback", readback, exp_rb(w, w2, 1'b0));
        chk("t4_accepts", accepts - a0, 2);
        @(posedge clk); #1;

        // Reset in the middle of bit 5
        w = WIDTH'($urandom) | 12'h020;
        start_load(w);
        cfg_valid = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        chk("t5_pre_dta", shift_dta, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_outputs", {shift_clk, shift_dta, busy, done}, 0);
        chk("t5_rst_ready", cfg_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_load("t5_123", 12'h123);

        // Tail stuck low
        stuck = 1'b1;
        w = WIDTH'($urandom) | 12'h001;
        do_load("t6_stuck", w);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_sticky_mismatch", mismatch, exp_mm(12'h000, w));
        chk("t6_held_readback", readback, 0);
        stuck = 1'b0;
        preload(12'h0AA);
        do_load("t6_5a5", 12'h5A5);
        do_load("t6_recheck", WIDTH'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
